// File: rtl/vga_frame_fetch_pkg.sv
// vga_frame_fetch shared types and constants.
// Optional test-pattern path is enabled with TEST_PATTERN_EN.
package vga_frame_fetch_pkg;

  localparam int LOG_MEM    = 36;
  localparam int LOG_HCOUNT = 11;
  localparam int LOG_VCOUNT = 10;
  localparam int LOG_ADDR   = 19;

  localparam int VGA_HACTIVE = 640;
  localparam int VGA_VACTIVE = 480;
  localparam int LINE_WORDS  = 320;
  localparam int RD_LAT      = 1;

  localparam logic [LOG_ADDR-1:0] BANK1_BASE = 19'h40000;

  // YCrCb colour bars, left to right
  localparam logic [17:0] BAR_LUT [8] = '{
    18'h3F_F80, 18'h3A_0A0, 18'h2E_8F0, 18'h29_990,
    18'h1A_670, 18'h15_710, 18'h09_F60, 18'h04_200
  };

  typedef enum logic {
    SHOW    = 1'b0,
    PENDING = 1'b1
  } bank_state_e;

endpackage

// File: rtl/vga_frame_fetch_if.sv
// Display-side request/response and ZBT read port bundle.
// test_pattern exists only when TEST_PATTERN_EN is defined.
interface vga_frame_fetch_if;
  import vga_frame_fetch_pkg::*;

  logic                  vga_flag;
  logic [LOG_HCOUNT-1:0] hcount;
  logic [LOG_VCOUNT-1:0] vcount;
  logic [LOG_MEM-1:0]    vga_pixel;
  logic                  done_vga;
  logic                  frame_done;
  logic                  frame_flag;
  logic                  display_bank;
  logic                  write_bank;
  logic                  mem_re;
  logic [LOG_ADDR-1:0]   mem_addr;
  logic [LOG_MEM-1:0]    mem_rdata;
  logic [7:0]            drop_count;
`ifdef TEST_PATTERN_EN
  logic                  test_pattern;

  modport slave (
    input  vga_flag, hcount, vcount, frame_done,
    input  mem_rdata, test_pattern,
    output vga_pixel, done_vga, frame_flag,
    output display_bank, write_bank,
    output mem_re, mem_addr, drop_count
  );

  modport master (
    output vga_flag, hcount, vcount, frame_done,
    output mem_rdata, test_pattern,
    input  vga_pixel, done_vga, frame_flag,
    input  display_bank, write_bank,
    input  mem_re, mem_addr, drop_count
  );
`else
  modport slave (
    input  vga_flag, hcount, vcount, frame_done,
    input  mem_rdata,
    output vga_pixel, done_vga, frame_flag,
    output display_bank, write_bank,
    output mem_re, mem_addr, drop_count
  );

  modport master (
    output vga_flag, hcount, vcount, frame_done,
    output mem_rdata,
    input  vga_pixel, done_vga, frame_flag,
    input  display_bank, write_bank,
    input  mem_re, mem_addr, drop_count
  );
`endif

endinterface

// File: rtl/vga_addr_gen.sv
// (bank, hcount, vcount) -> ZBT word address and active-area flag.
// Row offset is vcount*320 built from two shifts.
module vga_addr_gen
  import vga_frame_fetch_pkg::*;
(
  input  logic                  bank_i,
  input  logic [LOG_HCOUNT-1:0] hcount_i,
  input  logic [LOG_VCOUNT-1:0] vcount_i,
  output logic [LOG_ADDR-1:0]   addr_o,
  output logic                  in_range_o
);

  logic [LOG_ADDR-1:0] v_ext;
  logic [LOG_ADDR-1:0] row_off;
  logic [LOG_ADDR-1:0] col_off;
  logic [LOG_ADDR-1:0] base;

  assign v_ext   = {{(LOG_ADDR-LOG_VCOUNT){1'b0}}, vcount_i};
  assign row_off = (v_ext << 8) + (v_ext << 6);
  assign col_off = {{(LOG_ADDR-9){1'b0}}, hcount_i[9:1]};
  assign base    = bank_i ? BANK1_BASE : '0;
  assign addr_o  = base + row_off + col_off;

  assign in_range_o =
    (hcount_i < LOG_HCOUNT'(VGA_HACTIVE)) &&
    (vcount_i < LOG_VCOUNT'(VGA_VACTIVE));

endmodule

// File: rtl/vga_frame_fetch.sv
// Frame-buffer fetch for the display stage with double-buffer bank swap.
// Define TEST_PATTERN_EN for the colour-bar test source.
module vga_frame_fetch
  import vga_frame_fetch_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  vga_frame_fetch_if.slave   bus
);

  bank_state_e         state_q;
  logic                disp_q;
  logic                flag_q;
  logic [7:0]          drop_q;
  logic                s1_vld_q;
  logic                s1_inr_q;
  logic                done_q;
  logic [LOG_MEM-1:0]  pix_q;
  logic [LOG_MEM-1:0]  pix_d;

  logic                in_range;
  logic                is_origin;
  logic                swap_now;
  logic                bank_eff;
  logic                tp_on;
  logic [LOG_ADDR-1:0] addr;

  assign is_origin = (bus.hcount == '0) && (bus.vcount == '0);
  assign swap_now  = (state_q == PENDING) && bus.vga_flag &&
                     is_origin && !reset;
  assign bank_eff  = swap_now ? ~disp_q : disp_q;

  vga_addr_gen u_addr (
    .bank_i     (bank_eff),
    .hcount_i   (bus.hcount),
    .vcount_i   (bus.vcount),
    .addr_o     (addr),
    .in_range_o (in_range)
  );

`ifdef TEST_PATTERN_EN
  logic       s1_tp_q;
  logic [2:0] s1_bar_q;

  assign tp_on = bus.test_pattern;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_tp_q  <= 1'b0;
      s1_bar_q <= '0;
    end else begin
      s1_tp_q  <= bus.test_pattern;
      s1_bar_q <= bus.hcount[9:7];
    end
  end

  always_comb begin
    pix_d = '0;
    if (s1_inr_q)
      pix_d = s1_tp_q ? {2{BAR_LUT[s1_bar_q]}} : bus.mem_rdata;
  end
`else
  assign tp_on = 1'b0;

  always_comb begin
    pix_d = '0;
    if (s1_inr_q)
      pix_d = bus.mem_rdata;
  end
`endif

  assign bus.mem_re   = bus.vga_flag && in_range && !tp_on && !reset;
  assign bus.mem_addr = addr;

  // Bank FSM; a frame_done during the swap re-arms immediately
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= SHOW;
      disp_q  <= 1'b0;
      flag_q  <= 1'b0;
      drop_q  <= '0;
    end else begin
      flag_q <= swap_now;
      unique case (state_q)
        SHOW: begin
          if (bus.frame_done)
            state_q <= PENDING;
        end
        PENDING: begin
          if (swap_now) begin
            disp_q  <= ~disp_q;
            state_q <= bus.frame_done ? PENDING : SHOW;
          end else if (bus.frame_done && drop_q != 8'hFF) begin
            drop_q <= drop_q + 8'd1;
          end
        end
        default: state_q <= SHOW;
      endcase
    end
  end

  // mem_rdata arrives one clock after mem_re, straight into stage 2
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_vld_q <= 1'b0;
      s1_inr_q <= 1'b0;
      done_q   <= 1'b0;
      pix_q    <= '0;
    end else begin
      s1_vld_q <= bus.vga_flag;
      s1_inr_q <= in_range;
      done_q   <= s1_vld_q;
      if (s1_vld_q)
        pix_q <= pix_d;
    end
  end

  assign bus.vga_pixel    = pix_q;
  assign bus.done_vga     = done_q;
  assign bus.frame_flag   = flag_q;
  assign bus.display_bank = disp_q;
  assign bus.write_bank   = ~disp_q;
  assign bus.drop_count   = drop_q;

endmodule

// File: tb/tb_vga_frame_fetch.sv
// Directed bench for vga_frame_fetch with a response scoreboard.
// Build with TEST_PATTERN_EN to cover the colour-bar path.
module tb_vga_frame_fetch;
  import vga_frame_fetch_pkg::*;

  typedef struct {
    int                 due;
    logic [LOG_MEM-1:0] data;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t q[$];

  always #5 clock = ~clock;

  vga_frame_fetch_if bus ();

  vga_frame_fetch dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [LOG_MEM-1:0] memf(
    input logic [LOG_ADDR-1:0] a
  );
    return {a, ~a[16:0]};
  endfunction

  // ZBT model: one-clock read latency, junk when idle
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (bus.mem_re)
      bus.mem_rdata <= memf(bus.mem_addr);
    else
      bus.mem_rdata <= {4'hA, $urandom};
  end

  always @(negedge clock) begin
    bit exp_d;
    while (q.size() > 0 && q[0].due < cyc)
      void'(q.pop_front());
    exp_d = (q.size() > 0) && (q[0].due == cyc);
    total++;
    assert (bus.done_vga === exp_d) else begin
      bad++;
      $error("FAIL done_vga cyc=%0d got=%b exp=%b",
             cyc, bus.done_vga, exp_d);
    end
    if (exp_d) begin
      total++;
      assert (bus.vga_pixel === q[0].data) else begin
        bad++;
        $error("FAIL vga_pixel cyc=%0d got=%h exp=%h",
               cyc, bus.vga_pixel, q[0].data);
      end
      void'(q.pop_front());
    end
  end

  task automatic chk(input string nm,
                     input logic [35:0] got,
                     input logic [35:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic drive(input bit f, input int h,
                       input int v, input bit fd,
                       input bit tp);
    bus.vga_flag   = f;
    bus.hcount     = LOG_HCOUNT'(h);
    bus.vcount     = LOG_VCOUNT'(v);
    bus.frame_done = fd;
`ifdef TEST_PATTERN_EN
    bus.test_pattern = tp;
`else
    if (tp) $error("FAIL test_pattern unsupported");
`endif
  endtask

  task automatic req(input int h, input int v,
                     input bit exp_re,
                     input logic [LOG_ADDR-1:0] exp_a,
                     input bit fd = 1'b0,
                     input bit tp = 1'b0);
    exp_t e;
    bit inr;
    logic [2:0] bar;
    @(negedge clock);
    drive(1'b1, h, v, fd, tp);
    #1;
    chk("mem_re", bus.mem_re, exp_re);
    if (exp_re) chk("mem_addr", bus.mem_addr, exp_a);
    inr = (h < 640) && (v < 480);
    bar = 3'((h >> 7) & 7);
    e.due  = cyc + 2;
    e.data = !inr ? '0 :
             tp   ? {2{BAR_LUT[bar]}} : memf(exp_a);
    q.push_back(e);
  endtask

  task automatic idle();
    @(negedge clock);
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    #1;
  endtask

  task automatic pulse_fd();
    @(negedge clock);
    drive(1'b0, 0, 0, 1'b1, 1'b0);
    #1;
  endtask

  initial begin
    bus.mem_rdata = '0;
    drive(1'b1, 0, 0, 1'b0, 1'b0);
    repeat (3) @(negedge clock);
    #1;
    chk("mem_re_in_reset", bus.mem_re, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    #1;
    chk("rst_pixel", bus.vga_pixel, 36'd0);
    chk("rst_flag", bus.frame_flag, 1'b0);
    chk("rst_disp", bus.display_bank, 1'b0);
    chk("rst_wr", bus.write_bank, 1'b1);
    chk("rst_drop", bus.drop_count, 8'd0);

    // back-to-back in bank 0, including the far corner
    req(0, 0, 1'b1, 19'd0);
    req(2, 0, 1'b1, 19'd1);
    req(639, 479, 1'b1, 19'd153599);
    req(3, 2, 1'b1, 19'd641);
    idle();
    idle();

    // out of range
    req(640, 10, 1'b0, 19'd0);
    req(4, 480, 1'b0, 19'd0);
    idle();
    idle();

    // arm then swap at (0,0)
    pulse_fd();
    req(0, 0, 1'b1, 19'h40000);
    idle();
    chk("swap1_flag", bus.frame_flag, 1'b1);
    chk("swap1_disp", bus.display_bank, 1'b1);
    chk("swap1_wr", bus.write_bank, 1'b0);
    idle();
    chk("swap1_flag_off", bus.frame_flag, 1'b0);

    // next frame without frame_done stays on bank 1
    req(0, 0, 1'b1, 19'h40000);
    idle();
    chk("noswap_flag", bus.frame_flag, 1'b0);

    // three frame_done pulses: two drops, one swap
    pulse_fd();
    pulse_fd();
    pulse_fd();
    req(0, 0, 1'b1, 19'd0);
    idle();
    chk("drop_flag", bus.frame_flag, 1'b1);
    chk("drop_disp", bus.display_bank, 1'b0);
    chk("drop_cnt", bus.drop_count, 8'd2);
    req(0, 0, 1'b1, 19'd0);
    idle();
    chk("drop_single", bus.frame_flag, 1'b0);

    // frame_done with (0,0) in SHOW only arms
    req(0, 0, 1'b1, 19'd0, 1'b1);
    idle();
    chk("coin_show_flag", bus.frame_flag, 1'b0);
    chk("coin_show_disp", bus.display_bank, 1'b0);
    req(0, 0, 1'b1, 19'h40000);
    idle();
    chk("coin_next_flag", bus.frame_flag, 1'b1);
    chk("coin_next_disp", bus.display_bank, 1'b1);

    // frame_done during the swap re-arms, no drop
    pulse_fd();
    req(0, 0, 1'b1, 19'd0, 1'b1);
    idle();
    chk("rearm_flag", bus.frame_flag, 1'b1);
    chk("rearm_disp", bus.display_bank, 1'b0);
    chk("rearm_drop", bus.drop_count, 8'd2);
    req(0, 0, 1'b1, 19'h40000);
    idle();
    chk("rearm2_flag", bus.frame_flag, 1'b1);
    chk("rearm2_disp", bus.display_bank, 1'b1);

    // reset the cycle after a request discards it
    pulse_fd();
    req(10, 5, 1'b1, 19'h40000 + 19'd1605);
    @(negedge clock);
    reset = 1'b1;
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    q.delete();
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rrst_done", bus.done_vga, 1'b0);
    chk("rrst_disp", bus.display_bank, 1'b0);
    chk("rrst_drop", bus.drop_count, 8'd0);
    req(0, 0, 1'b1, 19'd0);
    idle();
    chk("rrst_noswap", bus.frame_flag, 1'b0);
    req(2, 1, 1'b1, 19'd321);
    idle();

`ifdef TEST_PATTERN_EN
    req(200, 3, 1'b0, 19'd0, 1'b0, 1'b1);
    req(639, 0, 1'b0, 19'd0, 1'b0, 1'b1);
    req(700, 3, 1'b0, 19'd0, 1'b0, 1'b1);
    req(6, 0, 1'b1, 19'd3);
    idle();
`endif

    repeat (4) idle();
    total++;
    assert (q.size() == 0) else begin
      bad++;
      $error("FAIL drain left=%0d exp=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_frame_fetch.md
Name: vga_frame_fetch

Overview:
- Services the display output stage's per-pixel-pair read requests from the ZBT frame memory.
- Translates (hcount, vcount) into a double-buffered ZBT word address and issues the read.
- Returns the 36-bit word at a fixed latency of 2 clocks.
- Owns display/write bank selection: swaps banks once per frame on the writer's frame_done handshake and tells the display stage via frame_flag.

Parameters:
- BANK1_BASE, 19'h40000, ZBT word base address of bank 1 (bank 0 base is 0).
- LINE_WORDS, 320, 36-bit words per displayed line (two 18-bit YCrCb pixels per word).
- RD_LAT, 1, memory-port read latency in clocks from mem_re to mem_rdata valid. Must equal 1 so that request-to-pixel latency is 2.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- vga_flag  in  1  pixel-pair read request from display stage
- hcount  in  `LOG_HCOUNT  requested column
- vcount  in  `LOG_VCOUNT  requested row
- vga_pixel  out  `LOG_MEM  returned word: [35:18] odd pixel, [17:0] even pixel
- done_vga  out  1  vga_pixel valid strobe
- frame_done  in  1  1-cycle pulse from frame writer: write bank complete
- frame_flag  out  1  1-cycle pulse on bank swap
- display_bank  out  1  bank currently displayed
- write_bank  out  1  always ~display_bank
- mem_re  out  1  ZBT read strobe (combinational)
- mem_addr  out  `LOG_ADDR  ZBT word address (combinational)
- mem_rdata  in  `LOG_MEM  ZBT read data, valid RD_LAT after mem_re
- drop_count  out  8  frames dropped, saturating

Behaviour:
- Reset values:
  - vga_pixel=0, done_vga=0, frame_flag=0.
  - display_bank=0, write_bank=1, drop_count=0.
  - FSM=SHOW; pipeline valid bits cleared.
  - mem_re=0 while reset is high.
- Request decode, cycle N:
  - in_range = hcount<640 && vcount<480.
  - mem_re = vga_flag && in_range && !reset.
  - hcount[0] is ignored; an odd hcount addresses the same word as hcount-1.
  - mem_addr = base(bank_eff) + vcount*320 + hcount[9:1].
  - vcount*320 is computed as (vcount<<8)+(vcount<<6); no multiplier. Maximum offset 153599 fits in 18 bits.
- Pipeline:
  - Stage 1 (N+1) captures vga_flag, in_range and mem_rdata.
  - Stage 2 (N+2) registers vga_pixel and pulses done_vga=1.
  - Out-of-range requests return vga_pixel=0 with done_vga=1 and no mem_re.
  - When done_vga=0, vga_pixel holds its last value.
  - Back-to-back requests every cycle are supported at full throughput.
- Bank FSM:
  - SHOW:
    - frame_done -> PENDING.
  - PENDING:
    - A vga_flag request with hcount==0 && vcount==0 swaps the bank.
    - Swap: display_bank toggles and frame_flag=1 for 1 cycle, registered (asserted at N+1). Return to SHOW.
    - The triggering request and all later requests use the new bank: bank_eff = swap_now ? ~display_bank : display_bank.
    - frame_done while already PENDING, and not swapping this cycle, increments drop_count (saturating at 255); state stays PENDING.
- Simultaneous events:
  - frame_done in SHOW in the same cycle as the (0,0) request: arm only. The swap waits for the next frame's (0,0).
  - frame_done in PENDING in the same cycle as the swap: swap, then go to PENDING (not SHOW). No drop is counted.
- Reset mid-operation: in-flight pipeline results are discarded (done_vga=0 the cycle after reset) and the pending swap is lost.

Optional Feature:
- TEST_PATTERN_EN: when defined, adds input test_pattern (1 bit).
  - While test_pattern=1, mem_re is suppressed.
  - Stage 2 outputs {2{BAR_LUT[hcount[9:7]]}} for in-range requests instead of memory data, with identical latency and done_vga timing.
  - hcount[9:7] is pipelined alongside the request.
  - When not defined: no port, no LUT, memory path only.

Decomposition:
- params.v gains `LOG_ADDR (19), `VGA_HACTIVE (640), `VGA_VACTIVE (480), and the 8-entry 18-bit BAR_LUT constants.
- The existing `LOG_MEM, `LOG_HCOUNT and `LOG_VCOUNT are reused.
- One sub-module, vga_addr_gen: combinational (bank, hcount, vcount) -> mem_addr and in_range.

Test Plan:
- vga_flag with (hcount,vcount)=(0,0), then (2,0), (639,479) in consecutive cycles, bank 0 -> mem_addr 0, 1, 153599.
  - done_vga at N+2, N+3, N+4, each carrying the matching mem_rdata.
- vga_flag at (640,10) and (4,480) -> mem_re=0; done_vga=1 two cycles later with vga_pixel=0.
- frame_done pulse, then request (0,0) -> mem_addr=19'h40000 the same cycle; frame_flag pulse at N+1; display_bank=1, write_bank=0.
  - The next frame's (0,0) without frame_done -> address 19'h40000 again.
- Three frame_done pulses before (0,0) -> drop_count=2, a single swap.
  - frame_done coincident with the (0,0) request in SHOW -> no swap until the following frame.
- reset asserted the cycle after a request -> no done_vga; display_bank=0, drop_count=0.
- With TEST_PATTERN_EN and test_pattern=1, request at hcount=200 -> mem_re=0 and vga_pixel={2{BAR_LUT[1]}} at N+2.
